// File: rtl/scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_register_file
// Purpose  : Two-read / one-write integer register file with a per-register
//            pending-write scoreboard for a pipelined core. Decode/issue
//            reads operands and reserves destination registers; writeback
//            commits results and releases the reservations.
//            Features: configurable width/depth, optional hardwired-zero x0,
//            same-cycle write-to-read bypass, operand-ready flags and a
//            running count of pending registers.
// Ports    : CLK        clock, all state changes on the rising edge
//            RST        synchronous active-high reset
//            A1/A2      read addresses        -> RD1/RD2 data (combinational)
//                                             -> RDY1/RDY2 no write in flight
//            A3/WD3/WE3 writeback commit port
//            ISS_VALID/ISS_RD  destination reservation from issue
//            FLUSH      drops every reservation (and any same-cycle issue)
//            PEND_CNT   number of registers currently pending
// Revision : 1.0  initial release
// ============================================================================
module scoreboard_register_file #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            RDY1,
  output logic            RDY2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic            ISS_VALID,
  input  logic [AW-1:0]   ISS_RD,
  input  logic            FLUSH,
  output logic [AW:0]     PEND_CNT
);

  localparam int NREG    = 2 ** AW;
  localparam bit ZR      = (ZERO_REG != 0);
  localparam int NPORTS  = 2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic [AW:0]     pend_cnt;

  // --------------------------------------------------------------------------
  // Qualified write and issue requests. x0 (when hardwired) can neither be
  // written nor reserved; a flush squashes the issue but not the write.
  // --------------------------------------------------------------------------
  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = WE3 && !(ZR && (A3 == '0));
  assign iss_ok = ISS_VALID && !(ZR && (ISS_RD == '0)) && !FLUSH;

  // --------------------------------------------------------------------------
  // Register array. Each entry is its own flop bank so reset can clear the
  // whole array in one cycle. A hardwired x0 is never written (wr_ok is low
  // for it), so it simply holds its reset value.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREG; i++) begin : g_mem
    always_ff @(posedge CLK) begin
      if (RST) begin
        mem[i] <= '0;
      end else if (wr_ok && (A3 == AW'(i))) begin
        mem[i] <= WD3;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending scoreboard, next-state per register.
  // Priority: flush clears, then issue sets, then writeback clears. Issue
  // beats a same-register writeback because the new producer supersedes the
  // result that is committing now.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREG; i++) begin : g_pend
    logic set_i;
    logic clr_i;

    assign set_i = iss_ok && (ISS_RD == AW'(i));
    assign clr_i = wr_ok  && (A3     == AW'(i));

    if (ZR && (i == 0)) begin : g_zero
      // Hardwired zero is never pending; its request terms are unused.
      logic unused_req;
      assign unused_req      = set_i | clr_i;
      assign pending_next[i] = 1'b0;
    end else begin : g_norm
      always_comb begin
        pending_next[i] = pending[i];
        if (FLUSH) begin
          pending_next[i] = 1'b0;
        end else if (set_i) begin
          pending_next[i] = 1'b1;
        end else if (clr_i) begin
          pending_next[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // --------------------------------------------------------------------------
  // Pending counter, maintained incrementally. In one cycle at most one
  // register can become pending (the issue target) and at most one can be
  // released (the writeback target), so the change is -1, 0 or +1.
  // --------------------------------------------------------------------------
  logic          cnt_inc;
  logic          cnt_dec;
  logic [AW:0]   cnt_next;

  assign cnt_inc = |(pending_next & ~pending);
  assign cnt_dec = |(pending & ~pending_next);

  always_comb begin
    cnt_next = pend_cnt;
    if (FLUSH) begin
      cnt_next = '0;
    end else begin
      cnt_next = pend_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_cnt <= '0;
    end else begin
      pend_cnt <= cnt_next;
    end
  end

  assign PEND_CNT = pend_cnt;

  // --------------------------------------------------------------------------
  // Read ports: hardwired zero first, then write-first bypass, then array.
  // Ready: a same-cycle writeback to the register makes its value available
  // now, so it counts as ready even while the pending bit is still set.
  // --------------------------------------------------------------------------
  logic [AW-1:0]   rd_addr [NPORTS];
  logic [XLEN-1:0] rd_data [NPORTS];
  logic            rd_rdy  [NPORTS];

  assign rd_addr[0] = A1;
  assign rd_addr[1] = A2;

  for (genvar p = 0; p < NPORTS; p++) begin : g_rport
    logic is_zero;
    logic hit_wr;

    assign is_zero = ZR && (rd_addr[p] == '0);
    assign hit_wr  = wr_ok && (A3 == rd_addr[p]);

    always_comb begin
      rd_data[p] = mem[rd_addr[p]];
      rd_rdy[p]  = !pending[rd_addr[p]] || hit_wr;
      if (is_zero) begin
        rd_data[p] = '0;
        rd_rdy[p]  = 1'b1;
      end else if (hit_wr) begin
        rd_data[p] = WD3;
      end
    end
  end

  assign RD1  = rd_data[0];
  assign RD2  = rd_data[1];
  assign RDY1 = rd_rdy[0];
  assign RDY2 = rd_rdy[1];

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_register_file
// Purpose  : Self-checking bench for scoreboard_register_file. Two instances
//            (hardwired x0 and general x0) share one stimulus stream. The
//            driver computes expected outputs from a behavioural model and
//            queues them; a monitor on the falling edge pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_scoreboard_register_file;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [AW-1:0]   A1 = '0, A2 = '0, A3 = '0, ISS_RD = '0;
  logic [XLEN-1:0] WD3 = '0;
  logic            WE3 = 1'b0, ISS_VALID = 1'b0, FLUSH = 1'b0;

  logic [XLEN-1:0] rd1_z, rd2_z, rd1_n, rd2_n;
  logic            rdy1_z, rdy2_z, rdy1_n, rdy2_n;
  logic [AW:0]     cnt_z, cnt_n;

  always #5 CLK = ~CLK;

  scoreboard_register_file #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1)) u_dut_z (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(rd1_z), .RD2(rd2_z),
    .RDY1(rdy1_z), .RDY2(rdy2_z), .A3(A3), .WD3(WD3), .WE3(WE3),
    .ISS_VALID(ISS_VALID), .ISS_RD(ISS_RD), .FLUSH(FLUSH), .PEND_CNT(cnt_z)
  );

  scoreboard_register_file #(.XLEN(XLEN), .AW(AW), .ZERO_REG(0)) u_dut_n (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
    .RDY1(rdy1_n), .RDY2(rdy2_n), .A3(A3), .WD3(WD3), .WE3(WE3),
    .ISS_VALID(ISS_VALID), .ISS_RD(ISS_RD), .FLUSH(FLUSH), .PEND_CNT(cnt_n)
  );

  typedef struct packed {
    logic        chk;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rdy1;
    logic        rdy2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q_z[$];
  exp_t q_n[$];

  // Behavioural model: index 0 = hardwired x0, index 1 = general x0.
  logic [31:0] m_mem  [2][NREG];
  bit          m_pend [2][NREG];
  bit          done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < NREG; r++) begin
        m_mem[c][r]  = '0;
        m_pend[c][r] = 1'b0;
      end
  end

  function automatic exp_t model_out(input int c, input bit chk);
    exp_t e;
    bit   zr    = (c == 0);
    bit   wr_ok = WE3 && !(zr && A3 == 0);
    int   pc    = 0;
    e.chk = chk;
    if (zr && A1 == 0)              begin e.rd1 = 0;   e.rdy1 = 1; end
    else if (wr_ok && A3 == A1)     begin e.rd1 = WD3; e.rdy1 = 1; end
    else begin e.rd1 = m_mem[c][A1]; e.rdy1 = !m_pend[c][A1]; end
    if (zr && A2 == 0)              begin e.rd2 = 0;   e.rdy2 = 1; end
    else if (wr_ok && A3 == A2)     begin e.rd2 = WD3; e.rdy2 = 1; end
    else begin e.rd2 = m_mem[c][A2]; e.rdy2 = !m_pend[c][A2]; end
    for (int r = 0; r < NREG; r++) pc += m_pend[c][r];
    e.cnt = 6'(pc);
    return e;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      bit zr     = (c == 0);
      bit wr_ok  = WE3 && !(zr && A3 == 0);
      bit iss_ok = ISS_VALID && !(zr && ISS_RD == 0) && !FLUSH;
      if (RST) begin
        for (int r = 0; r < NREG; r++) begin
          m_mem[c][r] = '0; m_pend[c][r] = 0;
        end
      end else begin
        if (wr_ok) m_mem[c][A3] = WD3;
        if (FLUSH) begin
          for (int r = 0; r < NREG; r++) m_pend[c][r] = 0;
        end else begin
          if (wr_ok)  m_pend[c][A3]     = 0;
          if (iss_ok) m_pend[c][ISS_RD] = 1;  // issue wins over release
        end
      end
    end
  endtask

  // One cycle: drive inputs, queue expected outputs, advance the model.
  // Outputs are not checked during a reset cycle (state is being replaced).
  task automatic cyc(input bit rst, input bit [4:0] a1, input bit [4:0] a2,
                     input bit [4:0] a3, input bit [31:0] wd, input bit we,
                     input bit iv, input bit [4:0] ird, input bit fl);
    @(posedge CLK); #1;
    RST = rst; A1 = a1; A2 = a2; A3 = a3; WD3 = wd; WE3 = we;
    ISS_VALID = iv; ISS_RD = ird; FLUSH = fl;
    q_z.push_back(model_out(0, !rst));
    q_n.push_back(model_out(1, !rst));
    model_edge();
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every queued cycle is compared
  // at the falling edge that follows the drive.
  always @(negedge CLK) begin
    exp_t e;
    if (q_z.size() > 0) begin
      e = q_z.pop_front();
      if (e.chk) begin
        cmp("z.rd1", rd1_z, e.rd1);  cmp("z.rd2", rd2_z, e.rd2);
        cmp("z.rdy1", 32'(rdy1_z), 32'(e.rdy1));
        cmp("z.rdy2", 32'(rdy2_z), 32'(e.rdy2));
        cmp("z.cnt", 32'(cnt_z), 32'(e.cnt));
      end
    end
    if (q_n.size() > 0) begin
      e = q_n.pop_front();
      if (e.chk) begin
        cmp("n.rd1", rd1_n, e.rd1);  cmp("n.rd2", rd2_n, e.rd2);
        cmp("n.rdy1", 32'(rdy1_n), 32'(e.rdy1));
        cmp("n.rdy2", 32'(rdy2_n), 32'(e.rdy2));
        cmp("n.cnt", 32'(cnt_n), 32'(e.cnt));
      end
    end
    if (done) begin
      cmp("queue_drained", 32'(q_z.size() + q_n.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit [4:0] a1, a2, a3, ird;
    // Reset, then write-first bypass and array read of x5.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 0, 5, 32'hDEADBEEF, 1, 0, 0, 0);
    cyc(0, 5, 5, 0, 0, 0, 0, 0, 0);
    // Write to x0: zero in hardwired instance, stored in the other.
    cyc(0, 0, 0, 0, 32'h1234, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Issue x7, then writeback x7 with bypass, then count drops.
    cyc(0, 0, 7, 0, 0, 0, 1, 7, 0);
    cyc(0, 0, 7, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 7, 7, 32'h55, 1, 0, 0, 0);
    cyc(0, 0, 7, 0, 0, 0, 0, 0, 0);
    // x9: issue + writeback together while pending, then while not pending.
    cyc(0, 9, 9, 0, 0, 0, 1, 9, 0);
    cyc(0, 9, 9, 9, 32'h99, 1, 1, 9, 0);
    cyc(0, 9, 9, 0, 0, 0, 0, 0, 0);
    cyc(0, 9, 9, 9, 32'h77, 1, 0, 0, 0);
    cyc(0, 9, 9, 9, 32'h88, 1, 1, 9, 0);
    cyc(0, 9, 9, 0, 0, 0, 0, 0, 0);
    // Fill x1..x31, then flush with a simultaneous issue and write.
    for (int r = 1; r < 32; r++) cyc(0, 5'(r), 5'(r - 1), 0, 0, 0, 1, 5'(r), 0);
    cyc(0, 3, 31, 0, 0, 0, 0, 0, 0);
    cyc(0, 3, 10, 10, 32'hCAFE0010, 1, 1, 3, 1);
    cyc(0, 3, 10, 0, 0, 0, 0, 0, 0);
    // Reset during a write to a pending x4.
    cyc(0, 4, 4, 0, 0, 0, 1, 4, 0);
    cyc(1, 4, 4, 4, 32'hFF, 1, 0, 0, 0);
    cyc(0, 4, 4, 0, 0, 0, 0, 0, 0);
    // Randomised traffic with address collisions encouraged.
    for (int i = 0; i < 3000; i++) begin
      a3  = 5'($urandom_range(0, 31));
      ird = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? ird : 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 199) == 0, a1, a2, a3, $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ird,
          $urandom_range(0, 49) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    done = 1'b1;
  end

endmodule
`default_nettype wire
